propplug_tx: RTL and testbench
==============================

# propplug_tx

Serial host-side transmitter for the Propeller boot/serial interface. It emulates the sending half of a Prop Plug inside the FPGA fabric. It drives the line that feeds the Propeller's P31 receive pin, and it generates the DTR-style reset pulse on the Propeller's active-low reset input. Bytes are queued through a valid/ready port into a small FIFO and sent as 8N1 UART frames at a fixed clock divisor. The block sits beside `p1v` in board top-levels as an alternative to the external FTDI path.

## Interface

Parameters:
- `CLKDIV`, 1389 — clock cycles per bit (160 MHz / 115200); legal range 2..65535.
- `FIFO_AW`, 3 — FIFO address width; depth = 2**FIFO_AW = 8.
- `RES_LOW`, 1600 — cycles `resn_out` is held low per reset sequence; must be ≥ 1.
- `RES_WAIT`, 16000000 — cycles after `resn_out` rises before the first frame may start; must be ≥ 1.

Ports:
- `clock_160  in  1` — sole clock, rising edge.
- `reset  in  1` — synchronous, active-high.
- `tx_data  in  8` — byte to queue.
- `tx_valid  in  1` — `tx_data` is valid.
- `tx_ready  out  1` — FIFO can accept; a byte is accepted when `tx_valid & tx_ready`.
- `prop_reset_req  in  1` — single-cycle request to start a Propeller reset sequence.
- `resn_out  out  1` — to `p1v` `inp_resn`; active-low.
- `txd  out  1` — serial line to Propeller P31; idles high.
- `busy  out  1` — high when the state is not IDLE, or the FIFO is non-empty.
- `fifo_count  out  FIFO_AW+1` — bytes currently queued.

## Operation

- **States:** IDLE, RES_PULSE, RES_HOLD, START, DATA, STOP.
- **Reset values (while `reset` is high):** state=IDLE, FIFO empty, `txd`=1, `resn_out`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0, all counters 0.
- **FIFO:**
  - Circular, full/empty tracked with an extra pointer bit.
  - `tx_ready` = !full, and is 0 in RES_PULSE.
  - A push and a pop in the same cycle are both allowed when not full. `fifo_count` is unchanged in that case.
  - A pop when the FIFO is empty never occurs.
- **IDLE:** if the FIFO is non-empty, pop the head into the shift register and go to START.
- **START:** `txd`=0 for `CLKDIV` cycles, then go to DATA with bit index 0.
- **DATA:** `txd`=shift[0], LSB first. Each bit lasts `CLKDIV` cycles. After bit 7, go to STOP.
- **STOP:** `txd`=1 for `CLKDIV` cycles.
  - If the FIFO is non-empty at the end of STOP, pop and go directly to START. There is no idle gap between frames.
  - Otherwise go to IDLE.
- **Reset sequence:** `prop_reset_req`=1 in any state causes the following on the next edge:
  - The FIFO is flushed (count=0).
  - Any frame in progress is aborted.
  - `txd`=1, `resn_out`=0, state=RES_PULSE.
  - A push presented in the same cycle as the request is discarded.
- **RES_PULSE:** `resn_out`=0 for `RES_LOW` cycles, then `resn_out`=1 and go to RES_HOLD.
- **RES_HOLD:**
  - `txd`=1 for `RES_WAIT` cycles. The FIFO accepts pushes but nothing is popped.
  - When the count expires, go to IDLE.
- **Repeated requests:** `prop_reset_req` during RES_PULSE or RES_HOLD restarts the sequence from the beginning of RES_PULSE.
- **Width rules:**
  - The bit counter is wide enough for `CLKDIV-1`.
  - The reset counter is wide enough for max(`RES_LOW`, `RES_WAIT`) − 1.
  - Counters compare against parameter−1 and do not wrap.

## Timing

- **Push latency:** a push at edge N with the FIFO empty and state IDLE gives `fifo_count`=1 after edge N, `txd`=0 (start bit) after edge N+1, and `fifo_count` back to 0 after edge N+1.
- **Frame length:** exactly 10·`CLKDIV` cycles. Every bit boundary falls an exact multiple of `CLKDIV` cycles after the start-bit edge.
- **Reset timing:** request sampled at edge R gives `resn_out`=0 from R through R+`RES_LOW`, and 1 after edge R+`RES_LOW`. The earliest start bit is after edge R+`RES_LOW`+`RES_WAIT`+1.
- **Outputs are registered:** `txd`, `resn_out`, `fifo_count`.
- **Combinational outputs:** `tx_ready` and `busy` are decoded from registered state only. There is no combinational path from any input to any output.
- **Mid-operation reset:** `reset` asserted on any cycle restores all reset values on that edge. It takes priority over `prop_reset_req`.

## Test plan

Bench parameters: CLKDIV=16, FIFO_AW=3, RES_LOW=20, RES_WAIT=50.

- **Single byte:** push 0xA5 from IDLE → `txd` reads 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. The start bit begins 2 edges after the push. `busy` drops after 160 cycles.
- **Back-to-back and full:** push 0x00, 0xFF, 0x55 … until `tx_ready`=0 → 9 bytes are accepted (8 queued plus 1 popped). `fifo_count` peaks at 8. Frames are contiguous, with no extra high cycles between the stop bit and the next start bit.
- **Reset sequence:** pulse `prop_reset_req` with 3 bytes queued → `fifo_count`=0, `resn_out` low for exactly 20 cycles, `txd` high for the following 50 cycles, then IDLE with no frame sent.
- **Queue during hold:** push 0x3C during RES_HOLD → no start bit before the hold expires. The frame starts 1 edge after the transition to IDLE.
- **Abort and simultaneous push:** assert `prop_reset_req` during DATA bit 3, with `tx_valid`=1 in the same cycle → `txd` goes high on the next edge and the pushed byte is dropped (`fifo_count`=0).
- **Synchronous reset:** assert `reset` mid-frame, then release and push 0x81 → all outputs are at reset values the cycle after assertion, and a clean 0x81 frame follows.

Source files
------------

// File: rtl/propplug_tx.sv
// Host-side Prop Plug transmitter: byte FIFO feeding an 8N1 serial line, plus the
// reset-pulse/hold sequencer that drives the Propeller's active-low reset input.
module propplug_tx #(
  parameter int CLKDIV   = 1389,
  parameter int FIFO_AW  = 3,
  parameter int RES_LOW  = 1600,
  parameter int RES_WAIT = 16000000
) (
  input  logic               clock_160,
  input  logic               reset,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic               prop_reset_req,
  output logic               resn_out,
  output logic               txd,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = $clog2(CLKDIV);
  localparam int RMAX  = (RES_LOW > RES_WAIT) ? RES_LOW : RES_WAIT;
  localparam int RW    = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [BW-1:0]    BIT_LAST  = BW'(CLKDIV - 1);
  localparam logic [RW-1:0]    LOW_LAST  = RW'(RES_LOW - 1);
  localparam logic [RW-1:0]    WAIT_LAST = RW'(RES_WAIT - 1);
  localparam logic [FIFO_AW:0] PTR_ONE   = (FIFO_AW + 1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RES_PULSE, ST_RES_HOLD, ST_START, ST_DATA, ST_STOP
  } state_t;

  state_t             state_reg;
  logic [7:0]         mem [0:DEPTH-1];
  logic [FIFO_AW:0]   wr_ptr_reg;
  logic [FIFO_AW:0]   rd_ptr_reg;
  logic [FIFO_AW:0]   count_reg;
  logic [7:0]         shift_reg;
  logic [BW-1:0]      bit_cnt_reg;
  logic [2:0]         bit_idx_reg;
  logic [RW-1:0]      res_cnt_reg;
  logic               txd_reg;
  logic               resn_reg;

  logic fifo_empty;
  logic fifo_full;
  logic bit_end;
  logic push;
  logic pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                      (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
  assign bit_end    = (bit_cnt_reg == BIT_LAST);

  assign tx_ready   = !fifo_full && (state_reg != ST_RES_PULSE);
  assign busy       = (state_reg != ST_IDLE) || !fifo_empty;
  assign txd        = txd_reg;
  assign resn_out   = resn_reg;
  assign fifo_count = count_reg;

  // A push coinciding with a reset request is dropped along with the flushed queue.
  assign push = tx_valid && tx_ready && !prop_reset_req;
  assign pop  = !fifo_empty && !prop_reset_req &&
                ((state_reg == ST_IDLE) || (state_reg == ST_STOP && bit_end));

  always_ff @(posedge clock_160) begin
    if (push) begin
      mem[wr_ptr_reg[FIFO_AW-1:0]] <= tx_data;
    end
  end

  always_ff @(posedge clock_160) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      bit_idx_reg <= '0;
      res_cnt_reg <= '0;
      txd_reg     <= 1'b1;
      resn_reg    <= 1'b1;
    end else if (prop_reset_req) begin
      state_reg   <= ST_RES_PULSE;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      bit_cnt_reg <= '0;
      bit_idx_reg <= '0;
      res_cnt_reg <= '0;
      txd_reg     <= 1'b1;
      resn_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (push && !pop)      count_reg <= count_reg + PTR_ONE;
      else if (pop && !push) count_reg <= count_reg - PTR_ONE;

      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            shift_reg   <= mem[rd_ptr_reg[FIFO_AW-1:0]];
            bit_cnt_reg <= '0;
            txd_reg     <= 1'b0;
            state_reg   <= ST_START;
          end
        end
        ST_RES_PULSE: begin
          if (res_cnt_reg == LOW_LAST) begin
            res_cnt_reg <= '0;
            resn_reg    <= 1'b1;
            state_reg   <= ST_RES_HOLD;
          end else begin
            res_cnt_reg <= res_cnt_reg + RW'(1);
          end
        end
        ST_RES_HOLD: begin
          if (res_cnt_reg == WAIT_LAST) begin
            res_cnt_reg <= '0;
            state_reg   <= ST_IDLE;
          end else begin
            res_cnt_reg <= res_cnt_reg + RW'(1);
          end
        end
        ST_START: begin
          if (bit_end) begin
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            txd_reg     <= shift_reg[0];
            shift_reg   <= {1'b0, shift_reg[7:1]};
            state_reg   <= ST_DATA;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + BW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              txd_reg   <= 1'b1;
              state_reg <= ST_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              txd_reg     <= shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + BW'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            bit_cnt_reg <= '0;
            // Chain straight into the next start bit so frames stay gap-free.
            if (pop) begin
              shift_reg <= mem[rd_ptr_reg[FIFO_AW-1:0]];
              txd_reg   <= 1'b0;
              state_reg <= ST_START;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + BW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_propplug_tx.sv
// Directed bench for propplug_tx: frame bit timing, FIFO fill, reset sequencing,
// abort with simultaneous push, and synchronous reset recovery.
module tb_propplug_tx;

  logic       clock_160;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       prop_reset_req;
  logic       resn_out;
  logic       txd;
  logic       busy;
  logic [3:0] fifo_count;

  int n_checks;
  int n_fail;

  propplug_tx #(
    .CLKDIV  (16),
    .FIFO_AW (3),
    .RES_LOW (20),
    .RES_WAIT(50)
  ) dut (
    .clock_160     (clock_160),
    .reset         (reset),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .prop_reset_req(prop_reset_req),
    .resn_out      (resn_out),
    .txd           (txd),
    .busy          (busy),
    .fifo_count    (fifo_count)
  );

  initial clock_160 = 1'b0;
  always #5 clock_160 = ~clock_160;

  task automatic tick();
    @(posedge clock_160);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Positioned just after the start-bit edge plus 'first' cycles; walks to the end of the frame.
  task automatic check_frame(input logic [7:0] b, input int first);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int n = first; n < 160; n++) begin
      check_val("txd_bit", {31'd0, txd}, {31'd0, fr[n / 16]});
      if (n == 159) check_val("busy_in_frame", {31'd0, busy}, 32'd1);
      tick();
    end
    $display("frame 0x%02h checked from cycle %0d", b, first);
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  logic [7:0] burst [0:9];
  int accepted;

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    tx_data        = 8'h00;
    tx_valid       = 1'b0;
    prop_reset_req = 1'b0;
    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55; burst[3] = 8'h01; burst[4] = 8'h80;
    burst[5] = 8'h3C; burst[6] = 8'hC3; burst[7] = 8'h0F; burst[8] = 8'hF0; burst[9] = 8'hEE;

    // Reset values
    repeat (3) tick();
    check_val("rst_txd", {31'd0, txd}, 32'd1);
    check_val("rst_resn", {31'd0, resn_out}, 32'd1);
    check_val("rst_ready", {31'd0, tx_ready}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_count", {28'd0, fifo_count}, 32'd0);
    reset = 1'b0;
    tick();
    $display("reset state checked");

    // Single byte 0xA5
    push_byte(8'hA5);
    check_val("single_count_n", {28'd0, fifo_count}, 32'd1);
    check_val("single_txd_n", {31'd0, txd}, 32'd1);
    tick();
    check_val("single_count_n1", {28'd0, fifo_count}, 32'd0);
    check_frame(8'hA5, 0);
    check_val("single_busy_end", {31'd0, busy}, 32'd0);

    // Back-to-back fill until tx_ready drops
    accepted = 0;
    while (tx_ready && accepted < 10) begin
      tx_data  = burst[accepted];
      tx_valid = 1'b1;
      tick();
      accepted++;
      if (accepted >= 2)
        check_val("fill_count", {28'd0, fifo_count}, 32'(accepted - 1));
    end
    tx_valid = 1'b0;
    check_val("fill_accepted", 32'(accepted), 32'd9);
    check_val("fill_peak", {28'd0, fifo_count}, 32'd8);
    check_val("fill_ready_full", {31'd0, tx_ready}, 32'd0);
    tx_data  = burst[9];
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check_val("full_push_refused", {28'd0, fifo_count}, 32'd8);
    check_frame(burst[0], 8);
    for (int j = 1; j < 9; j++) begin
      check_val("b2b_count", {28'd0, fifo_count}, 32'(8 - j));
      check_frame(burst[j], 0);
    end
    check_val("b2b_busy_end", {31'd0, busy}, 32'd0);

    // Reset sequence with 3 bytes queued
    push_byte(8'h12); push_byte(8'h34); push_byte(8'h56); push_byte(8'h78);
    check_val("rs_count_pre", {28'd0, fifo_count}, 32'd3);
    check_val("rs_txd_pre", {31'd0, txd}, 32'd0);
    prop_reset_req = 1'b1;
    tick();
    prop_reset_req = 1'b0;
    check_val("rs_count_flush", {28'd0, fifo_count}, 32'd0);
    check_val("rs_busy", {31'd0, busy}, 32'd1);
    for (int c = 0; c < 70; c++) begin
      check_val("rs_resn", {31'd0, resn_out}, (c < 20) ? 32'd0 : 32'd1);
      check_val("rs_ready", {31'd0, tx_ready}, (c < 20) ? 32'd0 : 32'd1);
      check_val("rs_txd", {31'd0, txd}, 32'd1);
      tick();
    end
    check_val("rs_busy_end", {31'd0, busy}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      check_val("rs_no_frame", {31'd0, txd}, 32'd1);
      tick();
    end
    $display("reset sequence checked");

    // Queue during hold
    prop_reset_req = 1'b1;
    tick();
    prop_reset_req = 1'b0;
    repeat (25) tick();
    push_byte(8'h3C);
    for (int c = 26; c <= 70; c++) begin
      check_val("hold_txd", {31'd0, txd}, 32'd1);
      check_val("hold_count", {28'd0, fifo_count}, 32'd1);
      tick();
    end
    check_frame(8'h3C, 0);
    $display("queue during hold checked");

    // Abort during DATA bit 3 with simultaneous push
    push_byte(8'h96);
    tick();
    repeat (69) tick();
    check_val("abort_pre_bit3", {31'd0, txd}, 32'd0);
    prop_reset_req = 1'b1;
    tx_data        = 8'h77;
    tx_valid       = 1'b1;
    tick();
    prop_reset_req = 1'b0;
    tx_valid       = 1'b0;
    check_val("abort_txd", {31'd0, txd}, 32'd1);
    check_val("abort_count", {28'd0, fifo_count}, 32'd0);
    check_val("abort_resn", {31'd0, resn_out}, 32'd0);
    for (int c = 0; c < 75; c++) begin
      check_val("abort_line_idle", {31'd0, txd}, 32'd1);
      check_val("abort_count_stays", {28'd0, fifo_count}, 32'd0);
      tick();
    end
    check_val("abort_busy_end", {31'd0, busy}, 32'd0);
    $display("abort with push checked");

    // Synchronous reset mid-frame, taking priority over a reset request
    push_byte(8'h5A);
    push_byte(8'h6B);
    repeat (40) tick();
    reset          = 1'b1;
    prop_reset_req = 1'b1;
    tick();
    reset          = 1'b0;
    prop_reset_req = 1'b0;
    check_val("srst_txd", {31'd0, txd}, 32'd1);
    check_val("srst_resn", {31'd0, resn_out}, 32'd1);
    check_val("srst_ready", {31'd0, tx_ready}, 32'd1);
    check_val("srst_busy", {31'd0, busy}, 32'd0);
    check_val("srst_count", {28'd0, fifo_count}, 32'd0);
    tick();
    check_val("srst_resn_after", {31'd0, resn_out}, 32'd1);
    check_val("srst_txd_after", {31'd0, txd}, 32'd1);
    push_byte(8'h81);
    check_val("srst_push_count", {28'd0, fifo_count}, 32'd1);
    tick();
    check_frame(8'h81, 0);
    check_val("srst_busy_end", {31'd0, busy}, 32'd0);
    $display("synchronous reset checked");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
